// File: rtl/dot_product_stream_engine.sv
// Streaming dot-product engine.
// Two operand vectors arrive as 1..BEATS_MAX beats of LANES elements each.
// Stage 1 registers the per-lane products. Stage 2 sums the lanes and adds
// the sum to the accumulator. The result is held until downstream takes it.
//
// Handshakes: a transfer happens on any rising edge where valid && ready are
// both high. The source holds valid and its data stable until that edge.
// The sink may raise or lower ready at any time. in_valid/in_ready carry
// operand beats, and res_valid/res_ready carry the result. res_valid is held
// with a stable result until res_ready is seen.
module dot_product_stream_engine #(
    parameter int ELEM_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int BEATS_MAX  = 16,
    parameter int LEN_WIDTH  = 5,
    parameter int ACC_WIDTH  = 22
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        vec_len,
    input  logic                        signed_mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*ELEM_WIDTH-1:0] a_data,
    input  logic [LANES*ELEM_WIDTH-1:0] b_data,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [ACC_WIDTH-1:0]        result,
    output logic                        busy,
    output logic                        err_len
);

    localparam int PW = 2 * ELEM_WIDTH;
    localparam int XW = ACC_WIDTH - PW;
    localparam logic [LEN_WIDTH-1:0] BEATS_MAX_L = LEN_WIDTH'(BEATS_MAX);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [LEN_WIDTH-1:0]       len_q, len_d;
    logic                       signed_q, signed_d;
    logic [LEN_WIDTH-1:0]       cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic [LANES-1:0][PW-1:0]   prod_q, prod_d;
    logic                       s1_valid_q, s1_valid_d;
    logic                       s2_valid_q, s2_valid_d;
    logic                       res_valid_q, res_valid_d;
    logic [ACC_WIDTH-1:0]       result_q, result_d;
    logic                       err_len_q, err_len_d;

    logic                       accept;
    logic                       len_ok;
    logic [ELEM_WIDTH-1:0]      a_el, b_el;
    logic [PW-1:0]              sprod, uprod;
    logic [ACC_WIDTH-1:0]       lane_sum;

    assign accept    = in_valid && (state_q == ST_LOAD);
    assign len_ok    = (vec_len != '0) && (vec_len <= BEATS_MAX_L);
    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = res_valid_q;
    assign result    = result_q;
    assign err_len   = err_len_q;

    // Stage 1: per-lane products. The operands are extended to PW bits, so
    // the low PW bits of the product are correct for either signedness.
    always_comb begin
        prod_d     = prod_q;
        s1_valid_d = accept;
        a_el       = '0;
        b_el       = '0;
        sprod      = '0;
        uprod      = '0;
        if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                a_el  = a_data[(LANES-1-i)*ELEM_WIDTH +: ELEM_WIDTH];
                b_el  = b_data[(LANES-1-i)*ELEM_WIDTH +: ELEM_WIDTH];
                sprod = {{ELEM_WIDTH{a_el[ELEM_WIDTH-1]}}, a_el} *
                        {{ELEM_WIDTH{b_el[ELEM_WIDTH-1]}}, b_el};
                uprod = {{ELEM_WIDTH{1'b0}}, a_el} * {{ELEM_WIDTH{1'b0}}, b_el};
                prod_d[i] = signed_q ? sprod : uprod;
            end
        end
    end

    // Stage 2: extend the products to accumulator width and sum the lanes.
    always_comb begin
        lane_sum   = '0;
        s2_valid_d = s1_valid_q;
        for (int i = 0; i < LANES; i++) begin
            if (signed_q) begin
                lane_sum = lane_sum + {{XW{prod_q[i][PW-1]}}, prod_q[i]};
            end else begin
                lane_sum = lane_sum + {{XW{1'b0}}, prod_q[i]};
            end
        end
    end

    // Control FSM: operation sequencing, accumulation and the result register.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        signed_d    = signed_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        result_d    = result_q;
        err_len_d   = 1'b0;
        acc_d       = s1_valid_q ? (acc_q + lane_sum) : acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        state_d  = ST_LOAD;
                        len_d    = vec_len;
                        signed_d = signed_mode;
                        cnt_d    = '0;
                        acc_d    = '0;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Wait until the last beat has gone through both stages.
                if (!s1_valid_q && !s2_valid_q) begin
                    result_d    = acc_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            signed_q    <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            signed_q    <= signed_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
            err_len_q   <= err_len_d;
        end
    end

endmodule

// File: tb/tb_dot_product_stream_engine.sv
// Self-checking bench for dot_product_stream_engine.
// Expected results are queued when an operation is driven. They are popped
// and compared when res_valid rises.
module tb_dot_product_stream_engine;

    localparam int EW = 8;
    localparam int LANES = 4;
    localparam int BEATS_MAX = 16;
    localparam int LW = 5;
    localparam int AW = 22;
    localparam int DW = LANES * EW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [LW-1:0] vec_len;
    logic          signed_mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a_data;
    logic [DW-1:0] b_data;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] result;
    logic          busy;
    logic          err_len;

    dot_product_stream_engine #(
        .ELEM_WIDTH(EW), .LANES(LANES), .BEATS_MAX(BEATS_MAX),
        .LEN_WIDTH(LW), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
        .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .b_data(b_data), .res_valid(res_valid),
        .res_ready(res_ready), .result(result), .busy(busy), .err_len(err_len)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] last_exp;
    logic [AW-1:0] mon_e;
    logic          rv_prev = 1'b0;
    logic [DW-1:0] beat_a [BEATS_MAX];
    logic [DW-1:0] beat_b [BEATS_MAX];
    int            gap_before [BEATS_MAX];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare each new result against the oldest expectation.
    always @(negedge clk) begin
        if (res_valid && !rv_prev) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", 32'(result), 32'(mon_e));
            end
        end
        rv_prev = res_valid;
    end

    function automatic logic [DW-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {8'(e0), 8'(e1), 8'(e2), 8'(e3)};
    endfunction

    // Reference model: plain integer sum of element products.
    function automatic logic [AW-1:0] model(input int len, input bit sgn);
        longint sum;
        logic [EW-1:0] ea, eb;
        int va, vb;
        logic [DW-1:0] wa, wb;
        sum = 0;
        for (int b = 0; b < len; b++) begin
            wa = beat_a[b];
            wb = beat_b[b];
            for (int l = 0; l < LANES; l++) begin
                ea = wa[(LANES-1-l)*EW +: EW];
                eb = wb[(LANES-1-l)*EW +: EW];
                if (sgn) begin
                    va = int'(signed'(ea));
                    vb = int'(signed'(eb));
                end else begin
                    va = int'(ea);
                    vb = int'(eb);
                end
                sum = sum + longint'(va) * longint'(vb);
            end
        end
        return AW'(sum);
    endfunction

    // Driver tasks. Each one starts and ends 1 time unit after a rising edge.
    task automatic pulse_start(input int len, input bit sgn);
        start = 1'b1;
        vec_len = LW'(len);
        signed_mode = sgn;
        @(posedge clk); #1;
        start = 1'b0;
        signed_mode = ~sgn;
        vec_len = LW'($urandom_range(0, 31));
    endtask

    task automatic send_beats(input int len);
        int c;
        for (int b = 0; b < len; b++) begin
            in_valid = 1'b0;
            a_data = DW'($urandom);
            b_data = DW'($urandom);
            repeat (gap_before[b]) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            a_data = beat_a[b];
            b_data = beat_b[b];
            c = 0;
            while (!in_ready && c < 20) begin
                @(posedge clk); #1;
                c++;
            end
            if (c >= 20) begin
                check("in_ready_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input int len, input bit sgn, input logic [AW-1:0] exp);
        int cyc;
        exp_q.push_back(exp);
        last_exp = exp;
        pulse_start(len, sgn);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        send_beats(len);
        check({tag, "_in_ready_drop"}, 32'(in_ready), 32'd0);
        cyc = 0;
        while (!res_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd3);
        if (res_ready) begin
            cyc = 0;
            while (busy && cyc < 10) begin
                @(posedge clk); #1;
                cyc++;
            end
            check({tag, "_idle"}, 32'(busy), 32'd0);
            check({tag, "_result_kept"}, 32'(result), 32'(last_exp));
        end
    endtask

    task automatic zero_gaps();
        for (int b = 0; b < BEATS_MAX; b++) gap_before[b] = 0;
    endtask

    initial begin
        int len;
        bit sgn;
        rst = 1'b1; start = 1'b0; vec_len = '0; signed_mode = 1'b0;
        in_valid = 1'b0; a_data = '0; b_data = '0; res_ready = 1'b1;
        zero_gaps();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_len", 32'(err_len), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single beat, unsigned
        beat_a[0] = pack4(1, 2, 3, 4); beat_b[0] = pack4(1, 2, 3, 4);
        run_op("t1", 1, 1'b0, 22'd30);

        // Three beats with a two-cycle bubble before beat 2
        beat_a[1] = pack4(2, 3, 4, 5); beat_b[1] = pack4(2, 3, 4, 5);
        beat_a[2] = pack4(3, 4, 5, 6); beat_b[2] = pack4(3, 4, 5, 6);
        gap_before[1] = 2;
        run_op("t2", 3, 1'b0, 22'd170);
        zero_gaps();

        // Signed and unsigned interpretation of the same bits
        beat_a[0] = pack4(255, 255, 255, 255); beat_b[0] = pack4(2, 2, 2, 2);
        run_op("t3s", 1, 1'b1, 22'h3FFFF8);
        run_op("t3u", 1, 1'b0, 22'd2040);

        // Maximum length, maximum unsigned magnitude
        for (int b = 0; b < BEATS_MAX; b++) begin
            beat_a[b] = '1; beat_b[b] = '1;
        end
        run_op("t4", 16, 1'b0, 22'd4161600);

        // Result held with res_ready low; start ignored in DONE
        res_ready = 1'b0;
        beat_a[0] = pack4(1, 1, 1, 1); beat_b[0] = pack4(2, 2, 2, 2);
        run_op("t5", 1, 1'b0, 22'd8);
        for (int i = 0; i < 5; i++) begin
            start = (i == 1 || i == 3);
            vec_len = (i == 3) ? LW'(0) : LW'(1);
            @(posedge clk); #1;
            start = 1'b0;
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_result", 32'(result), 32'd8);
            check("hold_err_len", 32'(err_len), 32'd0);
        end
        res_ready = 1'b1;
        start = 1'b1; vec_len = LW'(1);
        @(posedge clk); #1;
        start = 1'b0;
        check("release_valid", 32'(res_valid), 32'd0);
        check("release_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("release_no_start", 32'(busy), 32'd0);
        check("release_no_err", 32'(err_len), 32'd0);

        // Illegal lengths
        pulse_start(0, 1'b0);
        check("len0_err", 32'(err_len), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("len0_err_pulse", 32'(err_len), 32'd0);
        pulse_start(17, 1'b0);
        check("len17_err", 32'(err_len), 32'd1);
        check("len17_busy", 32'(busy), 32'd0);
        check("len17_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("len17_err_pulse", 32'(err_len), 32'd0);

        // Reset in the middle of a four-beat operation
        beat_a[0] = pack4(9, 9, 9, 9); beat_b[0] = pack4(9, 9, 9, 9);
        beat_a[1] = pack4(7, 7, 7, 7); beat_b[1] = pack4(7, 7, 7, 7);
        pulse_start(4, 1'b0);
        send_beats(2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err_len", 32'(err_len), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_quiet", 32'(res_valid), 32'd0);
        beat_a[0] = pack4(1, 2, 3, 4); beat_b[0] = pack4(1, 2, 3, 4);
        run_op("t7", 1, 1'b0, 22'd30);

        // Random operations against the reference model
        for (int n = 0; n < 8; n++) begin
            len = $urandom_range(1, BEATS_MAX);
            sgn = 1'($urandom_range(0, 1));
            for (int b = 0; b < BEATS_MAX; b++) begin
                beat_a[b] = DW'($urandom);
                beat_b[b] = DW'($urandom);
                gap_before[b] = $urandom_range(0, 2);
            end
            run_op("rand", len, sgn, model(len, sgn));
        end
        zero_gaps();

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
